// File: rtl/mc_sequencer.sv
// Control sequencer for a multicycle MIPS-style core: IF/ID/EX/MEM/WB/HALT FSM with
// memory handshakes, syscall halt/display, and cycle / retired-instruction counters.
module mc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_src,
  output logic             branch_en,
  output logic             disp_we,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_JR, C_SYS, C_J, C_JAL, C_BR, C_IALU, C_LD, C_ST, C_ILL
  } class_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  class_t           cls;
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt_reg, instr_cnt_reg;

  always_comb begin
    cls = C_ILL;
    case (op)
      6'd0: begin
        case (func)
          6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34,
          6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43: cls = C_RALU;
          6'd8:    cls = C_JR;
          6'd12:   cls = C_SYS;
          default: cls = C_ILL;
        endcase
      end
      6'd2:                                  cls = C_J;
      6'd3:                                  cls = C_JAL;
      6'd1, 6'd4, 6'd5:                      cls = C_BR;
      6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14: cls = C_IALU;
      6'd35, 6'd37:                          cls = C_LD;
      6'd43:                                 cls = C_ST;
      default:                               cls = C_ILL;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    wb_src     = 2'd0;
    branch_en  = 1'b0;
    disp_we    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end
      end
      S_ID: state_next = (cls == C_ILL) ? S_IF : S_EX;
      S_EX: begin
        case (cls)
          C_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_IF;
          end
          C_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            reg_we     = 1'b1;
            wb_src     = 2'd2;
            state_next = S_IF;
          end
          C_JR: begin
            pc_write   = 1'b1;
            pc_src     = 2'd3;
            state_next = S_IF;
          end
          C_BR: begin
            branch_en  = 1'b1;
            pc_src     = 2'd1;
            state_next = S_IF;
          end
          C_SYS: begin
            if (halt_req) begin
              state_next = S_HALT;
            end else begin
              disp_we    = 1'b1;
              state_next = S_IF;
            end
          end
          C_RALU, C_IALU: state_next = S_WB;
          C_LD, C_ST:     state_next = S_MEM;
          default:        state_next = S_IF;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls == C_ST);
        if (mem_ack) state_next = (cls == C_LD) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_src     = (cls == C_LD) ? 2'd1 : 2'd0;
        state_next = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase
    // Reset silences every strobe immediately, even mid-handshake.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      wb_src    = 2'd0;
      branch_en = 1'b0;
      disp_we   = 1'b0;
      halted    = 1'b0;
    end
  end

  // An instruction retires when it returns to fetch, or when a syscall parks in HALT.
  assign retire = ((state_next == S_IF) && (state_reg inside {S_ID, S_EX, S_MEM, S_WB})) ||
                  ((state_next == S_HALT) && (state_reg != S_HALT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IF;
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg != S_HALT) cycle_cnt_reg <= cycle_cnt_reg + CNT_ONE;
      if (retire)              instr_cnt_reg <= instr_cnt_reg + CNT_ONE;
    end
  end

  assign state     = state_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the cycle and retired-instruction counters.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port op, input, 6 bits: instruction opcode, from the instruction register.
REQ-005 The block SHALL have port func, input, 6 bits: R-type function field.
REQ-006 The block SHALL have port halt_req, input, 1 bit: syscall halt condition (register $v0 == 10).
REQ-007 The block SHALL have port resume, input, 1 bit: leave the HALT state.
REQ-008 The block SHALL have port mem_ack, input, 1 bit: memory completion handshake.
REQ-009 The block SHALL have port mem_req, output, 1 bit: memory access request.
REQ-010 The block SHALL have port mem_we, output, 1 bit: memory write enable, valid only with mem_req.
REQ-011 The block SHALL have port iord, output, 1 bit: memory address select; 0 = PC, 1 = ALU result.
REQ-012 The block SHALL have port ir_write, output, 1 bit: load the instruction register.
REQ-013 The block SHALL have port pc_write, output, 1 bit: update the PC.
REQ-014 The block SHALL have port pc_src, output, 2 bits: PC source; 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs.
REQ-015 The block SHALL have port reg_we, output, 1 bit: register-file write enable.
REQ-016 The block SHALL have port wb_src, output, 2 bits: write-back source; 0 = ALU, 1 = memory, 2 = PC+4.
REQ-017 The block SHALL have port branch_en, output, 1 bit: PC is written only if the datapath branch condition holds.
REQ-018 The block SHALL have port disp_we, output, 1 bit: one-cycle strobe that latches $a0 into the display.
REQ-019 The block SHALL have port halted, output, 1 bit: high while in the HALT state.
REQ-020 The block SHALL have port state, output, 3 bits: current state encoding.
REQ-021 The block SHALL have port cycle_cnt, output, CNT_W bits: count of non-halted cycles.
REQ-022 The block SHALL have port instr_cnt, output, CNT_W bits: count of retired instructions.

Function
REQ-023 The state encoding SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to IF on the next cycle.
REQ-024 Instruction classes SHALL be decoded from op and func as follows:
- RALU: op 0 with func 0, 2, 3, 32, 33, 34, 36, 37, 38, 39, 42 or 43.
- JR: op 0, func 8.
- SYS: op 0, func 12.
- J: op 2. JAL: op 3.
- BR: op 1, 4 or 5.
- IALU: op 8, 9, 10, 12, 13 or 14.
- LD: op 35 or 37.
- ST: op 43.
- Anything else is ILL.
REQ-025 IF SHALL assert mem_req=1, iord=0, mem_we=0, and hold them until mem_ack is sampled high.
REQ-026 In the IF cycle where mem_ack=1, the block SHALL assert ir_write=1, pc_write=1 and pc_src=0, then go to ID.
REQ-027 ID SHALL last exactly one cycle and then go to EX; in ID an ILL instruction SHALL go to IF and retire as a no-op.
REQ-028 EX SHALL behave per class:
- J: pc_write=1, pc_src=2, then IF.
- JAL: as J, plus reg_we=1 and wb_src=2.
- JR: pc_write=1, pc_src=3, then IF.
- BR: branch_en=1, pc_src=1, then IF.
- SYS with halt_req=1: go to HALT.
- SYS with halt_req=0: disp_we=1, then IF.
- RALU or IALU: go to WB.
- LD or ST: go to MEM.
REQ-029 MEM SHALL assert mem_req=1, iord=1, and mem_we=1 only for ST, held until mem_ack.
REQ-030 On mem_ack in MEM, ST SHALL go to IF and LD SHALL go to WB.
REQ-031 WB SHALL assert reg_we=1 for one cycle (wb_src=1 for LD, 0 otherwise), then go to IF.
REQ-032 HALT SHALL hold all strobes at 0 with halted=1, and SHALL go to IF on the cycle after resume is sampled high.
REQ-033 Strobe outputs SHALL be combinational from state, op, func and mem_ack; state and counters SHALL be registered.
REQ-034 An asserted strobe value SHALL be 0 in any state where it is not specified above.
REQ-035 mem_ack outside IF and MEM SHALL be ignored.
REQ-036 mem_req SHALL never deassert before mem_ack is received.
REQ-037 cycle_cnt SHALL increment by 1 on every cycle not in HALT, and SHALL wrap from all-ones to 0.
REQ-038 instr_cnt SHALL increment by 1 on every transition into IF from ID, EX, MEM or WB, and on entry to HALT; it SHALL wrap modulo 2^CNT_W.
REQ-039 Latency with a zero-wait memory (mem_ack tied high) SHALL be:
- J, JAL, JR, BR and non-halting SYS: 3 cycles.
- RALU, IALU and ST: 4 cycles.
- LD: 5 cycles.
REQ-040 Each memory wait cycle SHALL add one cycle to the latency of REQ-039.

Reset
REQ-041 While rst_n=0 at a clock edge, the block SHALL set state to IF and clear cycle_cnt and instr_cnt to 0.
REQ-042 While rst_n=0, all strobes (mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_we, wb_src, branch_en, disp_we, halted) SHALL be forced to 0.
REQ-043 Reset SHALL take priority over every state, including mid-MEM with mem_req outstanding and HALT.
REQ-044 The first cycle after reset SHALL be IF with mem_req=1.

Verification
REQ-045 ADD with op=0, func=32 and mem_ack tied 1 -> state sequence IF, ID, EX, WB, IF; reg_we=1 with wb_src=0 only in WB; instr_cnt=1 after 4 cycles.
REQ-046 LW with op=35 and mem_ack delayed 2 cycles in both IF and MEM -> 9 cycles; mem_req held throughout each wait; reg_we=1 with wb_src=1 in WB.
REQ-047 JAL with op=3 -> in EX: pc_write=1, pc_src=2, reg_we=1, wb_src=2; back in IF after 3 cycles.
REQ-048 SYSCALL (op=0, func=12):
- With halt_req=0 -> disp_we pulses exactly once.
- With halt_req=1 -> halted=1 and cycle_cnt frozen; after resume=1 the next state is IF.
REQ-049 rst_n=0 during MEM of SW -> next cycle: state=0, mem_req forced 0 while rst_n stays low, both counters at 0.
REQ-050 cycle_cnt wrap: with CNT_W=4 after 15 cycles -> cycle_cnt=15, then 0 on the next cycle.
